// File: rtl/tt_um_array_multiplier_hhrb98.sv
// Unsigned 4x4 array multiplier tile: the AND-gate partial products are reduced by rows
// of rippling half/full adders, and the product is registered onto the dedicated output.

module ha_cell (
    input  logic a_i,
    input  logic b_i,
    output logic s_o,
    output logic c_o
);
    assign s_o = a_i ^ b_i;
    assign c_o = a_i & b_i;
endmodule

module fa_cell (
    input  logic a_i,
    input  logic b_i,
    input  logic c_i,
    output logic s_o,
    output logic c_o
);
    assign s_o = a_i ^ b_i ^ c_i;
    assign c_o = (a_i & b_i) | (c_i & (a_i ^ b_i));
endmodule

module tt_um_array_multiplier_hhrb98 (
`ifdef USE_POWER_PINS
    input  logic       VPWR,
    input  logic       VGND,
`endif
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] a,
    input  logic [7:0] b,
    output logic [7:0] p
);
    logic [3:0][3:0] pp;
    logic [3:0][3:0] s;
    logic [3:1][3:0] carry;
    logic [7:0]      prod;
    logic [7:0]      p_d;
    logic [7:0]      p_q;
    logic            unused_ok;

`ifdef USE_POWER_PINS
    assign unused_ok = &{1'b0, a[7:4], b[7:4], VPWR, VGND};
`else
    assign unused_ok = &{1'b0, a[7:4], b[7:4]};
`endif

    for (genvar i = 0; i < 4; i++) begin : g_pp
        for (genvar j = 0; j < 4; j++) begin : g_bit
            assign pp[i][j] = a[j] & b[i];
        end
    end

    assign s[0] = pp[0];

    // Row i adds pp[i] to the previous row shifted right by one; the previous
    // row's carry-out enters as its top bit, and the low sum bit retires to prod[i].
    for (genvar i = 1; i < 4; i++) begin : g_row
        logic [3:0] x;
        if (i == 1) begin : g_first
            assign x = {1'b0, s[0][3:1]};
        end else begin : g_next
            assign x = {carry[i-1][3], s[i-1][3:1]};
        end

        ha_cell u_ha (
            .a_i (x[0]),
            .b_i (pp[i][0]),
            .s_o (s[i][0]),
            .c_o (carry[i][0])
        );

        for (genvar j = 1; j < 4; j++) begin : g_fa
            fa_cell u_fa (
                .a_i (x[j]),
                .b_i (pp[i][j]),
                .c_i (carry[i][j-1]),
                .s_o (s[i][j]),
                .c_o (carry[i][j])
            );
        end
    end

    assign prod = {carry[3][3], s[3][3:0], s[2][0], s[1][0], s[0][0]};

    always_comb begin
        p_d = p_q;
        if (ena) begin
            p_d = prod;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p_q <= '0;
        end else begin
            p_q <= p_d;
        end
    end

    assign p = p_q;
endmodule

// File: tb/tb_tt_um_array_multiplier_hhrb98.sv
// Directed bench for the registered 4x4 array multiplier tile.

module tb_tt_um_array_multiplier_hhrb98;
    logic       clk;
    logic       rst_n;
    logic       ena;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] p;

    int checks   = 0;
    int failures = 0;

    tt_um_array_multiplier_hhrb98 dut (
`ifdef USE_POWER_PINS
        .VPWR  (1'b1),
        .VGND  (1'b0),
`endif
        .clk   (clk),
        .rst_n (rst_n),
        .ena   (ena),
        .a     (a),
        .b     (b),
        .p     (p)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle 1ns past it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        ena   = 1'b1;
        a     = 8'h0F;
        b     = 8'h0F;
        #1;
        checks++;
        if (p !== 8'h00) begin
            failures++;
            $display("FAIL reset_t0 p=%h expected=%h", p, 8'h00);
        end
        for (int unsigned k = 0; k < 3; k++) begin
            step();
            checks++;
            if (p !== 8'h00) begin
                failures++;
                $display("FAIL reset_hold edge=%0d p=%h expected=%h", k, p, 8'h00);
            end
            #4;
            checks++;
            if (p !== 8'h00) begin
                failures++;
                $display("FAIL reset_hold_mid edge=%0d p=%h expected=%h", k, p, 8'h00);
            end
        end
        @(negedge clk);
        rst_n = 1'b1;
        step();
        checks++;
        if (p !== 8'hE1) begin
            failures++;
            $display("FAIL reset_release p=%h expected=%h", p, 8'hE1);
        end
    endtask

    task automatic test_basic();
        logic [7:0] va [5];
        logic [7:0] vb [5];
        logic [7:0] ve [5];
        va = '{8'h03, 8'h07, 8'h00, 8'h01, 8'hA6};
        vb = '{8'h05, 8'h09, 8'h0C, 8'h0D, 8'h3B};
        ve = '{8'h0F, 8'h3F, 8'h00, 8'h0D, 8'h42};
        ena = 1'b1;
        for (int unsigned k = 0; k < 5; k++) begin
            a = va[k];
            b = vb[k];
            step();
            checks++;
            if (p !== ve[k]) begin
                failures++;
                $display("FAIL basic a=%h b=%h p=%h expected=%h", va[k], vb[k], p, ve[k]);
            end
        end
    endtask

    task automatic test_exhaustive();
        logic [3:0] hi_a;
        logic [3:0] hi_b;
        logic [7:0] exp_p;
        ena = 1'b1;
        for (int unsigned i = 0; i < 16; i++) begin
            for (int unsigned j = 0; j < 16; j++) begin
                hi_a  = 4'($urandom_range(0, 15));
                hi_b  = 4'($urandom_range(0, 15));
                a     = {hi_a, 4'(i)};
                b     = {hi_b, 4'(j)};
                exp_p = 8'(i * j);
                step();
                checks++;
                if (p !== exp_p) begin
                    failures++;
                    $display("FAIL exhaustive a=%h b=%h p=%h expected=%h", a, b, p, exp_p);
                end
            end
        end
    endtask

    task automatic test_enable_hold();
        ena = 1'b1;
        a   = 8'h04;
        b   = 8'h04;
        step();
        checks++;
        if (p !== 8'h10) begin
            failures++;
            $display("FAIL hold_load p=%h expected=%h", p, 8'h10);
        end
        ena = 1'b0;
        a   = 8'h09;
        b   = 8'h09;
        for (int unsigned k = 0; k < 3; k++) begin
            step();
            checks++;
            if (p !== 8'h10) begin
                failures++;
                $display("FAIL hold_disabled edge=%0d p=%h expected=%h", k, p, 8'h10);
            end
        end
        ena = 1'b1;
        step();
        checks++;
        if (p !== 8'h51) begin
            failures++;
            $display("FAIL hold_resume p=%h expected=%h", p, 8'h51);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] va [3];
        logic [7:0] vb [3];
        logic [7:0] ve [3];
        logic [7:0] prev;
        va   = '{8'h02, 8'h03, 8'h0F};
        vb   = '{8'h02, 8'h03, 8'h0E};
        ve   = '{8'h04, 8'h09, 8'hD2};
        prev = p;
        ena  = 1'b1;
        for (int unsigned k = 0; k < 3; k++) begin
            a = va[k];
            b = vb[k];
            #2;
            // New operands must not reach p before the next edge.
            checks++;
            if (p !== prev) begin
                failures++;
                $display("FAIL pipe_no_comb k=%0d p=%h expected=%h", k, p, prev);
            end
            step();
            checks++;
            if (p !== ve[k]) begin
                failures++;
                $display("FAIL pipe_seq k=%0d p=%h expected=%h", k, p, ve[k]);
            end
            prev = ve[k];
        end
    endtask

    task automatic test_async_reset();
        ena = 1'b1;
        a   = 8'h0F;
        b   = 8'h0E;
        step();
        checks++;
        if (p !== 8'hD2) begin
            failures++;
            $display("FAIL async_pre p=%h expected=%h", p, 8'hD2);
        end
        #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if (p !== 8'h00) begin
            failures++;
            $display("FAIL async_clear p=%h expected=%h", p, 8'h00);
        end
        rst_n = 1'b1;
        a     = 8'h05;
        b     = 8'h06;
        #1;
        checks++;
        if (p !== 8'h00) begin
            failures++;
            $display("FAIL async_stay p=%h expected=%h", p, 8'h00);
        end
        step();
        checks++;
        if (p !== 8'h1E) begin
            failures++;
            $display("FAIL async_recover p=%h expected=%h", p, 8'h1E);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_exhaustive();
        test_enable_hold();
        test_back_to_back();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/tt_um_array_multiplier_hhrb98.md
Name: tt_um_array_multiplier_hhrb98

Overview:
- Unsigned 4x4 array multiplier packaged as a Tiny Tapeout user tile.
- Operands come from the low nibbles of the two 8-bit input buses.
- The 8-bit product drives the dedicated output bus through an output register.
- The combinational core is a classic array multiplier: AND-gate partial products reduced by rows of half/full adder cells. Top-level glue registers the result.

Parameters:
- None. Operand width is fixed at 4 bits and product width at 8 bits.

Ports:
- clk    input   1  System clock; all state updates on the rising edge.
- rst_n  input   1  Asynchronous, active-low reset.
- ena    input   1  Tile enable; when low, the output register holds.
- a      input   8  Operand A bus (driven by ui_in); only a[3:0] is used.
- b      input   8  Operand B bus (driven by uio_in); only b[3:0] is used.
- p      output  8  Registered unsigned product a[3:0]*b[3:0].
- VPWR   input   1  Power pin. Present only when USE_POWER_PINS is defined; no logic function.
- VGND   input   1  Ground pin. Present only when USE_POWER_PINS is defined; no logic function.

Behaviour:
- Reset:
  - The only register is p_reg[7:0].
  - rst_n=0 clears p_reg to 0x00 immediately, without waiting for a clock edge.
  - p reads 0x00 for as long as rst_n is low, regardless of clk, ena, a and b.
  - Deasserting rst_n takes effect asynchronously; the first capture is the next rising edge with ena=1.
- Core (combinational):
  - Partial products pp[i][j] = a[j] & b[i] for i,j in 0..3.
  - Row 0 = pp[0].
  - Each subsequent row adds pp[i] shifted left by i using half/full adder cells, rippling carries within the row.
  - Final row carries form the upper product bits.
  - The result must equal the unsigned product for all 256 operand pairs. Maximum is 15*15=225 (0xE1), so no overflow beyond 8 bits.
  - The core is built from explicit half-adder and full-adder cells, not an inferred multiply operator.
- Register:
  - On a rising clk edge with rst_n=1 and ena=1: p_reg <= core product of the current a[3:0] and b[3:0].
  - On a rising edge with ena=0: p_reg holds its value.
  - Latency is exactly 1 clock from operand sampling to p.
  - Operands are sampled at the edge; changes between edges do not affect p.
  - p = p_reg, with no combinational path from a or b to p.
- Ignored inputs:
  - a[7:4] and b[7:4] have no effect on p under any condition.
- Simultaneous events:
  - Reset asserted at a clock edge wins; p = 0x00.
  - Reset asserted mid-operation discards the in-flight result.
- Throughput: one new product per clock while ena=1.
- The design emits no uio_out or uio_oe; the tile wrapper ties those buses to 0.

Test Plan:
1. Reset: hold rst_n=0 with a=0x0F, b=0x0F, ena=1, clk running -> p=0x00 throughout. After releasing rst_n, the first rising edge gives p=0xE1.
2. Basic products (ena=1, one edge each) -> p must equal:
   - a=3, b=5 -> 0x0F
   - a=7, b=9 -> 0x3F
   - a=0, b=12 -> 0x00
   - a=1, b=13 -> 0x0D
3. Exhaustive: sweep all 256 pairs of a[3:0] and b[3:0], with random upper nibbles -> p one cycle later equals a[3:0]*b[3:0]. Example: a=0xA6, b=0x3B -> p=0x42 (6*11).
4. Enable hold: load a=4, b=4 -> p=0x10. Then set ena=0 and apply a=9, b=9 for 3 edges -> p stays 0x10. Set ena=1 -> next edge p=0x51.
5. Latency/pipelining: change operands every cycle (2*2, 3*3, 15*14) -> p sequence 0x04, 0x09, 0xD2, each lagging its inputs by exactly one edge.
6. Async reset mid-run: with p=0xD2, pulse rst_n low between clock edges -> p goes to 0x00 before the next edge and recovers on the first enabled edge after release.
